ms_timer: RTL and testbench

Millisecond countdown timer that consumes the 1 kHz `tick` square wave produced by the system clock divider. Software or control logic loads a duration in milliseconds, pulses `start`, and receives a one-cycle `done` pulse when that many tick rising edges have elapsed. It sits directly downstream of the divider in the same `clk` domain and serves as the timing primitive for debounce, timeouts and LED/segment refresh logic.

---
 rtl/ms_timer.sv | 125 ++++++++++++
 tb/tb_ms_timer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_timer.sv
// ms_timer: millisecond countdown timer driven by the 1 kHz `tick` square wave
// from the system clock divider. A duration (in ms) is loaded with a one-cycle
// `start`; `done` pulses for one cycle once that many rising edges of `tick`
// have been counted.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   tick       1 kHz square wave, synchronous to clk; only rising edges count
//   start      single-cycle request to begin timing (only looked at in IDLE)
//   duration   target count in ms, sampled together with start
//   cancel     abort the current run without producing done
//   busy       high while a run is in progress (state RUN)
//   done       one-cycle pulse at expiry
//   elapsed_ms ms counted in the current or most recent run
//
// Handshake: start is a level sampled on each clk edge while IDLE; there is
// no ready output, a start seen outside IDLE is simply dropped (no queueing).
// done is a registered one-cycle strobe with no acknowledge.
//
// Build option: define MS_TIMER_AUTO_RELOAD_EN for periodic mode. At expiry
// the timer then pulses done, clears elapsed_ms and keeps running with the
// same duration until cancel or rst. A zero duration stays a one-shot.
//
// The FSM state is directly visible on busy (RUN <=> busy).

module ms_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] elapsed_ms
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             tick_q;
  logic             tick_rise;
  logic [WIDTH-1:0] dur_q;
  logic [WIDTH-1:0] dur_next;
  logic [WIDTH-1:0] elapsed_next;
  logic             done_next;
  logic [WIDTH:0]   elapsed_inc;
  logic             last_ms;

  // tick_q resets to 0, so a tick already high out of reset looks like an
  // edge for one cycle; that cycle is necessarily IDLE, where edges are
  // ignored, so no ms is counted until the next real rising edge.
  assign tick_rise = tick & ~tick_q;

  // One extra bit keeps the +1 comparison exact even at the maximum duration.
  assign elapsed_inc = {1'b0, elapsed_ms} + (WIDTH+1)'(1);
  assign last_ms     = (elapsed_inc == {1'b0, dur_q});

  always_comb begin
    state_next   = state;
    dur_next     = dur_q;
    elapsed_next = elapsed_ms;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        // cancel outranks a coincident start.
        if (start && !cancel) begin
          elapsed_next = '0;
          if (duration == '0) begin
            done_next = 1'b1;
          end else begin
            dur_next   = duration;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        // cancel outranks a coincident tick edge; elapsed_ms holds.
        if (cancel) begin
          state_next = IDLE;
        end else if (tick_rise) begin
          if (last_ms) begin
            done_next = 1'b1;
`ifdef MS_TIMER_AUTO_RELOAD_EN
            // Restart the period on the expiry edge itself so periods
            // chain with no lost edges.
            elapsed_next = '0;
`else
            elapsed_next = dur_q;
            state_next   = IDLE;
`endif
          end else begin
            elapsed_next = elapsed_inc[WIDTH-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_q     <= 1'b0;
      dur_q      <= '0;
      elapsed_ms <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      tick_q     <= tick;
      dur_q      <= dur_next;
      elapsed_ms <= elapsed_next;
      done       <= done_next;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_ms_timer.sv
// Testbench for ms_timer. tick toggles every 5 clk with a random phase.
// The reference model describes each accepted run by its accept cycle,
// duration and cancel cycle, and derives the expected outputs for any cycle
// by counting tick rising edges between those cycles.
// Inputs are driven 1 ns after the rising clk edge; outputs are checked at
// the same point, i.e. away from the active edge.

module tb_ms_timer;
  localparam int W     = 16;
  localparam int NEVER = 32'h7fff_ffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         start;
  logic         cancel;
  logic [W-1:0] duration;
  logic         busy;
  logic         done;
  logic [W-1:0] elapsed_ms;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int phase  = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    int a;       // cycle in which start (or rst) was presented
    int d;       // duration in ms
    int c;       // cycle in which cancel was presented, NEVER if none
    bit is_rst;  // record marks a reset instead of a run
  } run_t;
  run_t runs[$];

  always #5 clk = ~clk;

  ms_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .duration   (duration),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .elapsed_ms (elapsed_ms)
  );

  // ---------------- reference model ----------------
  function automatic bit tick_at(input int c);
    if (c < 0) return 1'b0;
    return (((c + phase) / 5) % 2) == 1;
  endfunction

  function automatic bit rise_at(input int c);
    return tick_at(c) && !tick_at(c - 1);
  endfunction

  // Number of tick rising edges in cycles c with lo < c < hi.
  function automatic int rises_between(input int lo, input int hi);
    int k = 0;
    for (int c = lo + 1; c < hi; c++) if (rise_at(c)) k++;
    return k;
  endfunction

  function automatic int nth_rise_after(input int a, input int n);
    int k = 0;
    for (int c = a + 1; c < a + 1 + 10 * n + 20; c++) begin
      if (rise_at(c)) begin
        k++;
        if (k == n) return c;
      end
    end
    return NEVER;
  endfunction

  // Expected outputs visible during cycle t.
  task automatic model_at(input int t, output bit eb, output bit ed, output int ee);
    int   idx = -1;
    int   n;
    int   lim;
    run_t r;
    eb = 1'b0; ed = 1'b0; ee = 0;
    for (int i = runs.size() - 1; i >= 0; i--)
      if (idx < 0 && runs[i].a < t) idx = i;
    if (idx < 0) return;
    r = runs[idx];
    if (r.is_rst) return;
    if (r.d == 0) begin
      ed = (t == r.a + 1);
      return;
    end
    lim = (t < r.c) ? t : r.c;
    n   = rises_between(r.a, lim);
`ifdef MS_TIMER_AUTO_RELOAD_EN
    ee = n % r.d;
    eb = (t <= r.c);
    ed = (t - 1 > r.a) && (t - 1 < r.c) && rise_at(t - 1) && (n % r.d == 0);
`else
    if (n >= r.d) begin
      ee = r.d;
      ed = (t == nth_rise_after(r.a, r.d) + 1);
    end else begin
      ee = n;
      eb = (t <= r.c);
    end
`endif
  endtask

  // Present inputs for the current cycle, log them in the model, advance.
  task automatic drive(input bit s, input int d, input bit c, input bit r);
    bit   eb, ed;
    int   ee;
    run_t last;
    start    = s;
    duration = d[W-1:0];
    cancel   = c;
    rst      = r;
    model_at(cyc, eb, ed, ee);
    if (r) begin
      runs.push_back('{cyc, 0, NEVER, 1'b1});
    end else if (c) begin
      if (eb) begin
        last   = runs[runs.size() - 1];
        last.c = cyc;
        runs[runs.size() - 1] = last;
      end
    end else if (s && !eb) begin
      runs.push_back('{cyc, d, NEVER, 1'b0});
    end
    @(posedge clk);
    #1;
    cyc++;
    tick = tick_at(cyc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit eb, ed; int ee;
    repeat (3) drive(0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || elapsed_ms !== '0) begin
      errors++;
      $display("FAIL reset_init busy/done/elapsed got %b/%b/%0d want 0/0/0", busy, done, elapsed_ms);
    end
    drive(1, 8, 0, 0);
    for (int k = 0; k < 45; k++) begin
      drive(0, 0, 0, 0);
      model_at(cyc, eb, ed, ee);
      checks++;
      if (busy !== eb || done !== ed || elapsed_ms !== ee[W-1:0]) begin
        errors++;
        $display("FAIL reset_run cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, busy, done, elapsed_ms, eb, ed, ee);
      end
    end
    drive(0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || elapsed_ms !== '0) begin
      errors++;
      $display("FAIL reset_midrun busy/done/elapsed got %b/%b/%0d want 0/0/0", busy, done, elapsed_ms);
    end
    for (int k = 0; k < 50; k++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet cyc=%0d busy/done got %b/%b want 0/0", cyc, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    bit eb, ed; int ee;
    int ndone = 0;
`ifdef MS_TIMER_AUTO_RELOAD_EN
    logic [W-1:0] done_elapsed = 0;
    logic         done_busy    = 1'b1;
`else
    logic [W-1:0] done_elapsed = 3;
    logic         done_busy    = 1'b0;
`endif
    drive(1, 3, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_rise got %b want 1", busy);
    end
    for (int k = 0; k < 60 && ndone == 0; k++) begin
      drive(0, 0, 0, 0);
      model_at(cyc, eb, ed, ee);
      checks++;
      if (busy !== eb || done !== ed || elapsed_ms !== ee[W-1:0]) begin
        errors++;
        $display("FAIL basic cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, busy, done, elapsed_ms, eb, ed, ee);
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (elapsed_ms !== done_elapsed || busy !== done_busy) begin
          errors++;
          $display("FAIL basic_done elapsed/busy got %0d/%b want %0d/%b", elapsed_ms, busy, done_elapsed, done_busy);
        end
      end
    end
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    checks++;
    if (ndone != 1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_count done pulses got %0d want 1 (done=%b busy=%b)", ndone, done, busy);
    end
  endtask

  task automatic test_zero();
    drive(1, 0, 0, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || elapsed_ms !== '0) begin
      errors++;
      $display("FAIL zero_done done/busy/elapsed got %b/%b/%0d want 1/0/0", done, busy, elapsed_ms);
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_after cyc=%0d done/busy got %b/%b want 0/0", cyc, done, busy);
      end
    end
  endtask

  task automatic test_cancel();
    bit eb, ed; int ee;
    int a = cyc;
    int c_at = nth_rise_after(a, 2);
    drive(1, 5, 0, 0);
    while (cyc < c_at) begin
      drive(0, 0, 0, 0);
      model_at(cyc, eb, ed, ee);
      checks++;
      if (busy !== eb || done !== ed || elapsed_ms !== ee[W-1:0]) begin
        errors++;
        $display("FAIL cancel_run cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, busy, done, elapsed_ms, eb, ed, ee);
      end
    end
    drive(0, 0, 1, 0);
    checks++;
    if (elapsed_ms !== 16'd1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_stop elapsed/busy/done got %0d/%b/%b want 1/0/0", elapsed_ms, busy, done);
    end
    for (int k = 0; k < 60; k++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (done !== 1'b0 || elapsed_ms !== 16'd1) begin
        errors++;
        $display("FAIL cancel_quiet cyc=%0d done/elapsed got %b/%0d want 0/1", cyc, done, elapsed_ms);
      end
    end
  endtask

`ifndef MS_TIMER_AUTO_RELOAD_EN
  task automatic test_back_to_back();
    bit eb, ed; int ee;
    logic [W-1:0] want;
    int ndone = 0;
    exp_q.push_back(16'd9);
    drive(1, 9, 0, 0);
    for (int k = 0; k < 200 && ndone < 2; k++) begin
      model_at(cyc, eb, ed, ee);
      checks++;
      if (busy !== eb || done !== ed || elapsed_ms !== ee[W-1:0]) begin
        errors++;
        $display("FAIL b2b cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, busy, done, elapsed_ms, eb, ed, ee);
      end
      if (done === 1'b1) begin
        ndone++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if (elapsed_ms !== want) begin
          errors++;
          $display("FAIL b2b_done elapsed got %0d want %0d", elapsed_ms, want);
        end
        if (ndone == 1) exp_q.push_back(16'd2);
      end
      if (ndone == 1 && done === 1'b1) drive(1, 2, 0, 0);
      else if (ndone == 0)             drive(1, 9, 0, 0);
      else                             drive(0, 0, 0, 0);
    end
    checks++;
    if (ndone != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count done pulses got %0d want 2 (pending %0d)", ndone, exp_q.size());
    end
  endtask
`else
  task automatic test_reload();
    bit eb, ed; int ee;
    int dcyc[$];
    drive(1, 4, 0, 0);
    for (int k = 0; k < 200 && dcyc.size() < 3; k++) begin
      drive(0, 0, 0, 0);
      model_at(cyc, eb, ed, ee);
      checks++;
      if (busy !== eb || done !== ed || elapsed_ms !== ee[W-1:0]) begin
        errors++;
        $display("FAIL reload cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, busy, done, elapsed_ms, eb, ed, ee);
      end
      if (done === 1'b1) dcyc.push_back(cyc);
    end
    checks++;
    if (dcyc.size() != 3) begin
      errors++;
      $display("FAIL reload_count done pulses got %0d want 3", dcyc.size());
    end else begin
      checks++;
      if (dcyc[1] - dcyc[0] != 40 || dcyc[2] - dcyc[1] != 40) begin
        errors++;
        $display("FAIL reload_period got %0d,%0d want 40,40", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
      end
    end
    drive(0, 0, 1, 0);
    for (int k = 0; k < 80; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reload_cancel cyc=%0d done/busy got %b/%b want 0/0", cyc, done, busy);
      end
      drive(0, 0, 0, 0);
    end
  endtask
`endif

  task automatic test_random();
    bit eb, ed; int ee;
    bit s, c, r;
    int d;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 99) < 15);
      d = ($urandom_range(0, 19) == 0) ? 65535 : $urandom_range(0, 6);
      drive(s, d, c, r);
      model_at(cyc, eb, ed, ee);
      checks++;
      if (busy !== eb || done !== ed || elapsed_ms !== ee[W-1:0]) begin
        errors++;
        $display("FAIL random cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, busy, done, elapsed_ms, eb, ed, ee);
      end
    end
  endtask

  initial begin
    phase = $urandom_range(0, 9);
    tick  = tick_at(0);
    test_reset();
    test_basic();
    test_zero();
    test_cancel();
`ifndef MS_TIMER_AUTO_RELOAD_EN
    test_back_to_back();
`else
    test_reload();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
